// File: rtl/sound_arbiter.sv
// Shares one SongPlayer between four sound-event sources: times each sound,
// forces a silent gap between sounds, lets higher indices preempt lower ones.
module sound_arbiter #(
  parameter int unsigned DUR0 = 25_000_000,
  parameter int unsigned DUR1 = 25_000_000,
  parameter int unsigned DUR2 = 50_000_000,
  parameter int unsigned DUR3 = 100_000_000,
  parameter int unsigned GAP  = 1_000_000,
  parameter int unsigned TW   = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [1:0] sound,
  output logic       playSound,
  output logic       busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam int unsigned DUR_TAB [4] = '{DUR0, DUR1, DUR2, DUR3};
  localparam logic [TW-1:0] GAP_M1 = TW'(GAP - 1);

  logic [TW-1:0] dur_m1 [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dur
      assign dur_m1[gi] = TW'(DUR_TAB[gi] - 1);
    end
  endgenerate

  logic [1:0]    state_q, state_d;
  logic [1:0]    sound_q, sound_d;
  logic          play_q, play_d;
  logic          busy_q, busy_d;
  logic [3:0]    pending_q, pending_d;
  logic [TW-1:0] timer_q, timer_d;

  logic [3:0] cand;
  logic [1:0] sel;
  logic [3:0] sel_onehot;
  logic [3:0] higher_mask;
  logic       preempt;

  assign cand = pending_q | req;

  always_comb begin
    sel = 2'd0;
    if (cand[3])      sel = 2'd3;
    else if (cand[2]) sel = 2'd2;
    else if (cand[1]) sel = 2'd1;
    else              sel = 2'd0;
  end

  assign sel_onehot  = 4'b0001 << sel;
  // Bits strictly above the sound now playing; only these may preempt it.
  assign higher_mask = 4'b1110 << sound_q;
  assign preempt     = |(req & higher_mask);

  always_comb begin
    state_d   = state_q;
    sound_d   = sound_q;
    play_d    = play_q;
    timer_d   = timer_q;
    pending_d = pending_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cand != 4'd0) begin
          sound_d   = sel;
          play_d    = 1'b1;
          timer_d   = dur_m1[sel];
          pending_d = cand & ~sel_onehot;
          state_d   = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // The interrupted sound is simply dropped; the preemptor waits in pending.
        pending_d = pending_q | req;
        if (preempt || timer_q == '0) begin
          play_d  = 1'b0;
          timer_d = GAP_M1;
          state_d = ST_GAP;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (timer_q != '0) begin
          timer_d   = timer_q - 1'b1;
          pending_d = pending_q | req;
        end else if (cand != 4'd0) begin
          sound_d   = sel;
          play_d    = 1'b1;
          timer_d   = dur_m1[sel];
          pending_d = cand & ~sel_onehot;
          state_d   = ST_PLAY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        play_d  = 1'b0;
        timer_d = '0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sound_q   <= 2'd0;
      play_q    <= 1'b0;
      busy_q    <= 1'b0;
      pending_q <= 4'd0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      sound_q   <= sound_d;
      play_q    <= play_d;
      busy_q    <= busy_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
    end
  end

  assign sound     = sound_q;
  assign playSound = play_q;
  assign busy      = busy_q;

endmodule
